// File: rtl/r4_sqrt_otf_ctrl_pkg.sv
// Shared types and constants for the radix-4 sqrt iteration controller and OTF root converter.
package r4_sqrt_pkg;

   localparam int RT_W_DEF     = 28;
   localparam int ITER_NUM_DEF = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   // One-hot root digits as produced by the QDS stage.
   localparam logic [4:0] RT_DIG_NEG_2 = 5'b10000;
   localparam logic [4:0] RT_DIG_NEG_1 = 5'b01000;
   localparam logic [4:0] RT_DIG_ZERO  = 5'b00100;
   localparam logic [4:0] RT_DIG_POS_1 = 5'b00010;
   localparam logic [4:0] RT_DIG_POS_2 = 5'b00001;

   function automatic logic is_onehot5(input logic [4:0] dig);
      return (dig != 5'b0) && ((dig & (dig - 5'd1)) == 5'b0);
   endfunction

endpackage

// File: rtl/r4_sqrt_otf_ctrl_if.sv
// Handshake and datapath bundle between the QDS stage, the controller and the result consumer.
interface r4_sqrt_otf_ctrl_if
   import r4_sqrt_pkg::*;
#(
   parameter int RT_W = RT_W_DEF
);
   logic            start_valid_i;
   logic            start_ready_o;
   logic [RT_W-1:0] rt_init_i;
   logic [RT_W-1:0] rt_m1_init_i;
   logic [4:0]      first_rt_dig_i;
   logic            kill_i;
   logic [4:0]      rt_dig_i;
   logic            iter_o;
   logic [4:0]      prev_rt_dig_o;
   logic [RT_W-1:0] rt_o;
   logic [RT_W-1:0] rt_m1_o;
   logic            finish_valid_o;
   logic            finish_ready_i;
   logic            dig_err_o;

   modport slave (
      input  start_valid_i, rt_init_i, rt_m1_init_i, first_rt_dig_i, kill_i, rt_dig_i,
             finish_ready_i,
      output start_ready_o, iter_o, prev_rt_dig_o, rt_o, rt_m1_o, finish_valid_o, dig_err_o
   );

   modport master (
      output start_valid_i, rt_init_i, rt_m1_init_i, first_rt_dig_i, kill_i, rt_dig_i,
             finish_ready_i,
      input  start_ready_o, iter_o, prev_rt_dig_o, rt_o, rt_m1_o, finish_valid_o, dig_err_o
   );
endinterface

// File: rtl/r4_sqrt_otf_ctrl_otf_update.sv
// Combinational on-the-fly root conversion step: next Q/QM from one radix-4 digit.
module r4_otf_update
   import r4_sqrt_pkg::*;
#(
   parameter int RT_W = RT_W_DEF
) (
   input  logic [RT_W-1:0] i_q,
   input  logic [RT_W-1:0] i_qm,
   input  logic [RT_W-1:0] i_mask,
   input  logic [4:0]      i_dig,
   output logic [RT_W-1:0] o_q,
   output logic [RT_W-1:0] o_qm
);
   logic [RT_W-1:0] w_hi;
   logic [RT_W-1:0] w_lo;

   // Upper and lower bit of the 2-bit digit field picked out by the mask.
   assign w_hi = i_mask & ~(i_mask >> 1);
   assign w_lo = i_mask & ~(i_mask << 1);

   // A non-one-hot digit ORs the selected cases together rather than prioritising one.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      o_q  = '0;
      o_qm = '0;
      if ((i_dig & RT_DIG_POS_2) != 5'b0) begin
         o_q  = o_q  | i_q | w_hi;
         o_qm = o_qm | i_q | w_lo;
      end
      if ((i_dig & RT_DIG_POS_1) != 5'b0) begin
         o_q  = o_q  | i_q | w_lo;
         o_qm = o_qm | i_q;
      end
      if ((i_dig & RT_DIG_ZERO) != 5'b0) begin
         o_q  = o_q  | i_q;
         o_qm = o_qm | i_qm | i_mask;
      end
      if ((i_dig & RT_DIG_NEG_1) != 5'b0) begin
         o_q  = o_q  | i_qm | i_mask;
         o_qm = o_qm | i_qm | w_hi;
      end
      if ((i_dig & RT_DIG_NEG_2) != 5'b0) begin
         o_q  = o_q  | i_qm | w_hi;
         o_qm = o_qm | i_qm | w_lo;
      end
   end
endmodule

// File: rtl/r4_sqrt_otf_ctrl.sv
// Radix-4 sqrt iteration controller and OTF root converter.
// Define R4_SQRT_OTF_DIG_CHK_EN to build the sticky non-one-hot digit check.
module r4_sqrt_otf_ctrl
   import r4_sqrt_pkg::*;
#(
   parameter int RT_W     = RT_W_DEF,
   parameter int ITER_NUM = ITER_NUM_DEF
) (
   input logic               clk,
   input logic               rst,
   r4_sqrt_otf_ctrl_if.slave bus
);
   localparam int              CNT_W     = $clog2(ITER_NUM + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ITER_NUM - 1);
   localparam logic [RT_W-1:0] MASK_INIT = {{(RT_W-2){1'b0}}, 2'b11} << (RT_W - 5);
   localparam logic [RT_W-1:0] GUARD     = {{(RT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [RT_W-1:0]  r_q;
   logic [RT_W-1:0]  r_qm;
   logic [RT_W-1:0]  r_mask;
   logic [CNT_W-1:0] r_iter_cnt;
   logic [4:0]       r_prev_dig;
   logic [RT_W-1:0]  w_q_nxt;
   logic [RT_W-1:0]  w_qm_nxt;
   logic             w_start_acc;
   logic             w_dig_acc;
   logic             w_dig_bad;
   logic             w_upd_en;

   assign w_start_acc = (r_state == IDLE) && bus.start_valid_i && !bus.kill_i;
   assign w_dig_acc   = (r_state == ITER) && !bus.kill_i;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_start_acc) w_state_nxt = ITER;
         ITER:    if (w_dig_acc && (r_iter_cnt == CNT_LAST)) w_state_nxt = DONE;
         DONE:    if (bus.finish_ready_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // Kill overrides both the start and the finish handshake.
      if (bus.kill_i) w_state_nxt = IDLE;
   end

   assign bus.start_ready_o  = (r_state == IDLE);
   assign bus.iter_o         = (r_state == ITER);
   assign bus.finish_valid_o = (r_state == DONE);

   r4_otf_update #(.RT_W(RT_W)) u_otf (
      .i_q    (r_q),
      .i_qm   (r_qm),
      .i_mask (r_mask),
      .i_dig  (bus.rt_dig_i),
      .o_q    (w_q_nxt),
      .o_qm   (w_qm_nxt)
   );

`ifdef R4_SQRT_OTF_DIG_CHK_EN
   logic r_dig_err;

   assign w_dig_bad = !is_onehot5(bus.rt_dig_i);

   always_ff @(posedge clk) begin
      if (rst)                           r_dig_err <= 1'b0;
      else if (w_start_acc)              r_dig_err <= 1'b0;
      else if (w_dig_acc && w_dig_bad)   r_dig_err <= 1'b1;
   end

   assign bus.dig_err_o = r_dig_err;
`else
   assign w_dig_bad     = 1'b0;
   assign bus.dig_err_o = 1'b0;
`endif

   assign w_upd_en = w_dig_acc && !w_dig_bad;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         r_q        <= '0;
         r_qm       <= '0;
         r_mask     <= '0;
         r_iter_cnt <= '0;
         r_prev_dig <= RT_DIG_ZERO;
      end else if (bus.kill_i) begin
         r_prev_dig <= RT_DIG_ZERO;
      end else if (w_start_acc) begin
         r_q        <= bus.rt_init_i;
         r_qm       <= bus.rt_m1_init_i;
         r_mask     <= MASK_INIT;
         r_iter_cnt <= '0;
         r_prev_dig <= bus.first_rt_dig_i;
      end else if (w_dig_acc) begin
         r_mask     <= r_mask >> 2;
         r_iter_cnt <= r_iter_cnt + CNT_W'(1);
         if (w_upd_en) begin
            // Bit 0 is the guard position and keeps its init value in both registers.
            r_q        <= (w_q_nxt  & ~GUARD) | (r_q  & GUARD);
            r_qm       <= (w_qm_nxt & ~GUARD) | (r_qm & GUARD);
            r_prev_dig <= bus.rt_dig_i;
         end
      end
   end

   assign bus.rt_o          = r_q;
   assign bus.rt_m1_o       = r_qm;
   assign bus.prev_rt_dig_o = r_prev_dig;
endmodule

// File: tb/tb_r4_sqrt_otf_ctrl.sv
// Self-checking bench for r4_sqrt_otf_ctrl: vector table, directed corner sequences, random ops vs an arithmetic root model.
module tb_r4_sqrt_otf_ctrl;
   import r4_sqrt_pkg::*;

   localparam int RT_W     = 28;
   localparam int ITER_NUM = 12;

   typedef logic [RT_W-1:0]              rt_t;
   typedef logic [ITER_NUM-1:0][4:0]     digs_t;

   typedef struct {
      string      name;
      rt_t        q0;
      rt_t        qm0;
      logic [4:0] first;
      digs_t      digs;
      int         rdy_dly;
      rt_t        exp_q;
      rt_t        exp_qm;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   r4_sqrt_otf_ctrl_if #(.RT_W(RT_W)) bus ();

   r4_sqrt_otf_ctrl #(.RT_W(RT_W), .ITER_NUM(ITER_NUM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Signed value of a one-hot digit.
   function automatic int dig_val(input logic [4:0] d);
      case (d)
         RT_DIG_POS_2: return 2;
         RT_DIG_POS_1: return 1;
         RT_DIG_NEG_1: return -1;
         RT_DIG_NEG_2: return -2;
         default:      return 0;
      endcase
   endfunction

   // Root value is init plus each digit weighted by 4^-j at its bit position.
   function automatic rt_t model_q(input rt_t q0, input digs_t digs);
      rt_t v = q0;
      for (int j = 0; j < ITER_NUM; j++) begin
         int p = RT_W - 5 - 2 * j;
         int d = dig_val(digs[j]);
         if (d >= 0) v = v + (rt_t'(d) << p);
         else        v = v - (rt_t'(-d) << p);
      end
      return v;
   endfunction

   function automatic rt_t model_qm(input rt_t q);
      return q - (rt_t'(1) << (RT_W - 5 - 2 * (ITER_NUM - 1)));
   endfunction

   task automatic start_op(input rt_t q0, input rt_t qm0, input logic [4:0] first);
      bus.start_valid_i  = 1'b1;
      bus.rt_init_i      = q0;
      bus.rt_m1_init_i   = qm0;
      bus.first_rt_dig_i = first;
      tick();
      bus.start_valid_i  = 1'b0;
   endtask

   // Feed zero digits until done, then accept the result.
   task automatic drain();
      int n = 0;
      bus.rt_dig_i = RT_DIG_ZERO;
      while (!bus.finish_valid_o && n < 40) begin
         tick();
         n++;
      end
      bus.finish_ready_i = 1'b1;
      tick();
      bus.finish_ready_i = 1'b0;
   endtask

   task automatic run_op(input string nm, input rt_t q0, input rt_t qm0, input logic [4:0] first,
                         input digs_t digs, input int rdy_dly, output rt_t q, output rt_t qm);
      int         cyc = 0;
      logic [4:0] exp_prev;
      check($sformatf("%s.start_ready_pre", nm), bus.start_ready_o, 1);
      start_op(q0, qm0, first);
      exp_prev = first;
      while (!bus.finish_valid_o && cyc < 40) begin
         if (cyc < ITER_NUM) begin
            check($sformatf("%s.iter_c%0d", nm, cyc), bus.iter_o, 1);
            check($sformatf("%s.prev_c%0d", nm, cyc), bus.prev_rt_dig_o, exp_prev);
            bus.rt_dig_i = digs[cyc];
            exp_prev     = digs[cyc];
         end else begin
            bus.rt_dig_i = RT_DIG_ZERO;
         end
         tick();
         cyc++;
      end
      bus.rt_dig_i = RT_DIG_ZERO;
      check($sformatf("%s.latency", nm), cyc, ITER_NUM);
      check($sformatf("%s.prev_last", nm), bus.prev_rt_dig_o, exp_prev);
      check($sformatf("%s.iter_done", nm), bus.iter_o, 0);
      q  = bus.rt_o;
      qm = bus.rt_m1_o;
      for (int k = 0; k < rdy_dly; k++) begin
         check($sformatf("%s.hold_valid%0d", nm, k), bus.finish_valid_o, 1);
         check($sformatf("%s.hold_sready%0d", nm, k), bus.start_ready_o, 0);
         check($sformatf("%s.hold_q%0d", nm, k), bus.rt_o, q);
         check($sformatf("%s.hold_qm%0d", nm, k), bus.rt_m1_o, qm);
         tick();
      end
      bus.finish_ready_i = 1'b1;
      tick();
      bus.finish_ready_i = 1'b0;
      check($sformatf("%s.start_ready_post", nm), bus.start_ready_o, 1);
      check($sformatf("%s.valid_post", nm), bus.finish_valid_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t  vecs[5];
      rt_t   q, qm;
      digs_t dz;

      rst                = 1'b1;
      bus.start_valid_i  = 1'b0;
      bus.rt_init_i      = '0;
      bus.rt_m1_init_i   = '0;
      bus.first_rt_dig_i = RT_DIG_ZERO;
      bus.kill_i         = 1'b0;
      bus.rt_dig_i       = RT_DIG_ZERO;
      bus.finish_ready_i = 1'b0;
      dz                 = {ITER_NUM{RT_DIG_ZERO}};

      vecs[0] = '{"zeros",  28'h8000000, 28'h6000000, RT_DIG_ZERO,  dz, 0, 28'h8000000, 28'h7FFFFFE};
      vecs[1] = '{"p2first",28'h8000000, 28'h6000000, RT_DIG_ZERO,  dz, 1, 28'h9000000, 28'h8FFFFFE};
      vecs[1].digs[0] = RT_DIG_POS_2;
      vecs[2] = '{"allp2",  28'h8000000, 28'h6000000, RT_DIG_POS_1, {ITER_NUM{RT_DIG_POS_2}}, 2,
                  28'h9555554, 28'h9555552};
      vecs[3] = '{"m1first",28'h8000000, 28'h6000000, RT_DIG_NEG_2, dz, 0, 28'h7800000, 28'h77FFFFE};
      vecs[3].digs[0] = RT_DIG_NEG_1;
      vecs[4] = '{"allm2",  28'h8000000, 28'h6000000, RT_DIG_POS_2, {ITER_NUM{RT_DIG_NEG_2}}, 4,
                  28'h6AAAAAC, 28'h6AAAAAA};

      tick();
      tick();
      rst = 1'b0;
      check("rst.start_ready", bus.start_ready_o, 1);
      check("rst.iter", bus.iter_o, 0);
      check("rst.finish_valid", bus.finish_valid_o, 0);
      check("rst.prev_dig", bus.prev_rt_dig_o, RT_DIG_ZERO);
      check("rst.rt", bus.rt_o, 0);
      check("rst.rt_m1", bus.rt_m1_o, 0);
      check("rst.dig_err", bus.dig_err_o, 0);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].q0, vecs[i].qm0, vecs[i].first, vecs[i].digs,
                vecs[i].rdy_dly, q, qm);
         check($sformatf("%s.q", vecs[i].name), q, vecs[i].exp_q);
         check($sformatf("%s.qm", vecs[i].name), qm, vecs[i].exp_qm);
      end

      // First iteration digit -1 checked right after it is consumed.
      start_op(28'h8000000, 28'h6000000, RT_DIG_ZERO);
      bus.rt_dig_i = RT_DIG_NEG_1;
      tick();
      check("m1step.q", bus.rt_o, 28'h7800000);
      check("m1step.qm", bus.rt_m1_o, 28'h7000000);
      check("m1step.prev", bus.prev_rt_dig_o, RT_DIG_NEG_1);
      drain();

      // Kill in ITER cycle 5 together with a start request.
      start_op(28'h8000000, 28'h6000000, RT_DIG_POS_1);
      bus.rt_dig_i = RT_DIG_POS_1;
      repeat (4) tick();
      bus.kill_i        = 1'b1;
      bus.start_valid_i = 1'b1;
      bus.rt_dig_i      = RT_DIG_POS_2;
      tick();
      bus.kill_i        = 1'b0;
      bus.start_valid_i = 1'b0;
      bus.rt_dig_i      = RT_DIG_ZERO;
      check("kill.start_ready", bus.start_ready_o, 1);
      check("kill.iter", bus.iter_o, 0);
      check("kill.finish_valid", bus.finish_valid_o, 0);
      check("kill.prev", bus.prev_rt_dig_o, RT_DIG_ZERO);
      tick();
      check("kill.no_start", bus.iter_o, 0);
      check("kill.idle", bus.start_ready_o, 1);
      run_op("afterkill", 28'h8000000, 28'h6000000, RT_DIG_ZERO, dz, 0, q, qm);
      check("afterkill.q", q, 28'h8000000);
      check("afterkill.qm", qm, 28'h7FFFFFE);

      // Reset in the middle of an operation.
      start_op(28'hA000000, 28'h8000000, RT_DIG_POS_2);
      bus.rt_dig_i = RT_DIG_NEG_1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.rt_dig_i = RT_DIG_ZERO;
      check("midrst.start_ready", bus.start_ready_o, 1);
      check("midrst.iter", bus.iter_o, 0);
      check("midrst.prev", bus.prev_rt_dig_o, RT_DIG_ZERO);
      check("midrst.rt", bus.rt_o, 0);
      check("midrst.rt_m1", bus.rt_m1_o, 0);

`ifdef R4_SQRT_OTF_DIG_CHK_EN
      begin
         int cyc = 1;
         start_op(28'h8000000, 28'h6000000, RT_DIG_POS_1);
         bus.rt_dig_i = 5'b00011;
         tick();
         check("chk.err_set", bus.dig_err_o, 1);
         check("chk.q_hold", bus.rt_o, 28'h8000000);
         check("chk.qm_hold", bus.rt_m1_o, 28'h6000000);
         check("chk.prev_hold", bus.prev_rt_dig_o, RT_DIG_POS_1);
         bus.rt_dig_i = RT_DIG_ZERO;
         while (!bus.finish_valid_o && cyc < 40) begin
            tick();
            cyc++;
         end
         check("chk.latency", cyc, ITER_NUM);
         check("chk.q", bus.rt_o, 28'h8000000);
         check("chk.qm", bus.rt_m1_o, 28'h67FFFFE);
         bus.finish_ready_i = 1'b1;
         tick();
         bus.finish_ready_i = 1'b0;
         check("chk.err_sticky", bus.dig_err_o, 1);
         start_op(28'h8000000, 28'h6000000, RT_DIG_ZERO);
         check("chk.err_clear", bus.dig_err_o, 0);
         drain();
      end
`endif

      for (int n = 0; n < 25; n++) begin
         rt_t   q0, qm0;
         digs_t digs;
         logic [4:0] first;
         logic [4:0] pick[5];
         pick = '{RT_DIG_NEG_2, RT_DIG_NEG_1, RT_DIG_ZERO, RT_DIG_POS_1, RT_DIG_POS_2};
         q0    = rt_t'($urandom_range(4, 7)) << (RT_W - 3);
         qm0   = q0 - (rt_t'(1) << (RT_W - 3));
         first = pick[$urandom_range(0, 4)];
         for (int j = 0; j < ITER_NUM; j++) digs[j] = pick[$urandom_range(0, 4)];
         run_op($sformatf("rnd%0d", n), q0, qm0, first, digs, int'($urandom_range(0, 3)), q, qm);
         check($sformatf("rnd%0d.q", n), q, model_q(q0, digs));
         check($sformatf("rnd%0d.qm", n), qm, model_qm(model_q(q0, digs)));
         check($sformatf("rnd%0d.dig_err", n), bus.dig_err_o, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/r4_sqrt_otf_ctrl.md
Name: r4_sqrt_otf_ctrl

Overview:
Iteration controller and on-the-fly (OTF) root converter for the radix-4 scalar fp sqrt. It sits directly downstream of the radix-4 speculative digit-selection stage. Each cycle it consumes the one-hot root digit from that stage and updates the root Q and root-minus-ulp QM registers. It also registers the digit that the selection stage needs as its previous-digit select on the next cycle, counts iterations, and runs the start/finish handshake.

Parameters:
RT_W, 28, root width: bit RT_W-1 is the integer bit, then fraction bits.
ITER_NUM, 12, number of radix-4 iterations after the first digit; requires ITER_NUM <= (RT_W-3)/2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_valid_i  in  1  new operation request
start_ready_o  out  1  high only in IDLE
rt_init_i  in  RT_W  Q after the first digit (bits RT_W-1..RT_W-3 valid)
rt_m1_init_i  in  RT_W  QM after the first digit
first_rt_dig_i  in  5  one-hot first digit, loaded into prev_rt_dig_o
kill_i  in  1  abort the current operation
rt_dig_i  in  5  one-hot digit from the QDS stage: [4]=-2, [3]=-1, [2]=0, [1]=+1, [0]=+2
iter_o  out  1  high in ITER; the remainder datapath advances when it is high
prev_rt_dig_o  out  5  registered last digit, fed back to the QDS stage
rt_o  out  RT_W  final Q
rt_m1_o  out  RT_W  final QM
finish_valid_o  out  1  result valid
finish_ready_i  in  1  consumer accepts the result
dig_err_o  out  1  sticky non-one-hot digit flag; see Optional Feature

Behaviour:
- Reset values:
  - state = IDLE; start_ready_o = 1; iter_o = 0; finish_valid_o = 0.
  - prev_rt_dig_o = 5'b00100 (digit 0).
  - rt_o = 0; rt_m1_o = 0; mask = 0; iter_cnt = 0; dig_err_o = 0.
- States:
  - IDLE -> ITER on start_valid_i & start_ready_o.
  - ITER -> DONE when iter_cnt == ITER_NUM-1 and a digit is consumed.
  - DONE -> IDLE on finish_ready_i.
- Start accept: load Q = rt_init_i, QM = rt_m1_init_i, prev_rt_dig_o = first_rt_dig_i, iter_cnt = 0, mask = 2'b11 << (RT_W-5).
- ITER cycle, with p = the 2-bit field selected by mask, OR-ed into the base register:
  - d=+2: Q = Q|10, QM = Q|01.
  - d=+1: Q = Q|01, QM = Q|00.
  - d=0: Q = Q|00, QM = QM|11.
  - d=-1: Q = QM|11, QM = QM|10.
  - d=-2: Q = QM|10, QM = QM|01.
  - In the same cycle: mask >>= 2, iter_cnt++, prev_rt_dig_o = rt_dig_i.
- Bit 0 of Q/QM is never written by the OTF update and stays at its init value (guard position).
- Latency: with start accepted at cycle 0, digits are consumed in cycles 1..ITER_NUM and finish_valid_o goes high in cycle ITER_NUM+1. It holds, with rt_o/rt_m1_o stable, until finish_ready_i.
- In DONE, finish_valid_o & finish_ready_i returns to IDLE, and start_ready_o = 1 on the next cycle. There is no start bypass in DONE.
- kill_i in any state -> IDLE next cycle:
  - finish_valid_o and iter_o are cleared, prev_rt_dig_o = 5'b00100.
  - Q/QM are held (don't-care).
  - kill_i beats a simultaneous start or finish handshake; no start is accepted that cycle.
- rst mid-operation: identical to the reset values above.
- rt_dig_i is ignored outside ITER.
- Non-one-hot rt_dig_i in ITER is a protocol violation:
  - Without the feature: the update is the OR of the selected cases (undefined result).
  - With the feature: see Optional Feature.
- iter_cnt width is $clog2(ITER_NUM+1).

Optional Feature:
R4_SQRT_OTF_DIG_CHK_EN:
- When defined: in ITER, a non-one-hot rt_dig_i sets dig_err_o, which is sticky until start accept or rst. That cycle's Q/QM/prev_rt_dig_o update is suppressed (hold), while mask and iter_cnt still advance.
- When not defined: dig_err_o is tied to 0 and no check logic is built.

Decomposition:
- Shared package r4_sqrt_pkg holds:
  - the state enum (IDLE, ITER, DONE);
  - the one-hot digit constants RT_DIG_NEG_2..RT_DIG_POS_2 and RT_DIG_ZERO = 5'b00100;
  - the RT_W default.
- Natural sub-module r4_otf_update: purely combinational next-Q/QM from (Q, QM, mask, digit); reusable by the radix-16 wrapper, which chains two of them per cycle.

Test Plan:
1. RT_W=28, ITER_NUM=12, rt_init=28'h8000000, rt_m1_init=28'h6000000, 12 zero digits -> finish_valid_o in cycle 13; rt_o=28'h8000000, rt_m1_o=28'h7FFFFFE.
2. Same init, first iteration digit +2 then 11 zeros -> rt_o=28'h9000000, rt_m1_o=28'h8FFFFFE.
3. Same init, first iteration digit -1 -> after that cycle Q=28'h7800000, QM=28'h7000000, prev_rt_dig_o=5'b01000.
4. kill_i asserted in ITER cycle 5 together with start_valid_i -> IDLE next cycle, prev_rt_dig_o=5'b00100, no finish_valid_o; the next start runs a full 12 iterations.
5. finish_ready_i held low for 4 cycles in DONE -> finish_valid_o and rt_o stable; start_ready_o=0 until the cycle after finish_ready_i.
6. With R4_SQRT_OTF_DIG_CHK_EN, rt_dig_i=5'b00011 in ITER -> dig_err_o=1 from the next cycle, Q/QM unchanged that cycle, still 12 cycles to finish.
